// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared constants, state type and helpers for the seven-segment scan controller
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    // Active-low patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [6:0] SEG_0   = 7'h40;
    localparam logic [6:0] SEG_1   = 7'h79;
    localparam logic [6:0] SEG_2   = 7'h24;
    localparam logic [6:0] SEG_3   = 7'h30;
    localparam logic [6:0] SEG_4   = 7'h19;
    localparam logic [6:0] SEG_5   = 7'h12;
    localparam logic [6:0] SEG_6   = 7'h02;
    localparam logic [6:0] SEG_7   = 7'h78;
    localparam logic [6:0] SEG_8   = 7'h00;
    localparam logic [6:0] SEG_9   = 7'h10;
    localparam logic [6:0] SEG_A   = 7'h08;
    localparam logic [6:0] SEG_B   = 7'h03;
    localparam logic [6:0] SEG_C   = 7'h46;
    localparam logic [6:0] SEG_D   = 7'h21;
    localparam logic [6:0] SEG_E   = 7'h06;
    localparam logic [6:0] SEG_F   = 7'h0E;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;

    // Active-low anode pattern selecting a single digit
    function automatic logic [NUM_DIGITS-1:0] an_select(input logic [1:0] dig);
        an_select = ~(4'b0001 << dig);
    endfunction

    // Digits 3..1 that are zero with no decimal point and only leading zeros above them
    function automatic logic [NUM_DIGITS-1:0] leading_zero_mask(input logic [15:0] val,
                                                                input logic [3:0]  dp);
        logic [NUM_DIGITS-1:0] m;
        m[3] = (val[15:12] == 4'h0) && !dp[3];
        m[2] = m[3] && (val[11:8] == 4'h0) && !dp[2];
        m[1] = m[2] && (val[7:4] == 4'h0) && !dp[1];
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational hex nibble to active-low seven-segment pattern
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - 4-digit multiplexed display scanner, frame-synchronous double buffer; SEG7_LEADING_ZERO_BLANK_EN enables leading-zero blanking
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int TICK_DIV    = 100000,
    parameter int BLANK_TICKS = 1,
    parameter int ON_TICKS    = 4
) (
    input  logic        clk_100MHz,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp_n,
    output logic        frame_done
);

    localparam int TW   = $clog2(TICK_DIV);
    localparam int PMAX = (BLANK_TICKS > ON_TICKS) ? BLANK_TICKS : ON_TICKS;
    localparam int PW   = $clog2(PMAX + 1);

    localparam logic [TW-1:0] TCNT_LAST  = TW'(TICK_DIV - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_TICKS - 1);
    localparam logic [PW-1:0] ON_LAST    = PW'(ON_TICKS - 1);

    logic [TW-1:0] tcnt;
    logic          tick;
    logic [PW-1:0] pcnt, pcnt_nxt;
    scan_state_t   state, state_nxt;
    logic [1:0]    dig, dig_nxt;
    logic          boundary;

    // Enables are held inverted so a cleared register means every digit is lit
    logic [15:0] act_val, act_val_nxt, pnd_val;
    logic [3:0]  act_dp, act_dp_nxt, pnd_dp;
    logic [3:0]  act_dis, act_dis_nxt, pnd_dis;
    logic        pend, pend_nxt;

    logic [3:0]  nibble;
    logic [6:0]  seg_dec;
    logic [3:0]  lz_mask;
    logic        dark;
    logic [3:0]  an_nxt;
    logic [6:0]  seg_nxt;
    logic        dp_n_nxt;

    assign tick = (tcnt == TCNT_LAST);

    always_comb begin
        state_nxt = state;
        pcnt_nxt  = pcnt;
        dig_nxt   = dig;
        boundary  = 1'b0;
        case (state)
            BLANK: begin
                if (tick) begin
                    if (pcnt == BLANK_LAST) begin
                        state_nxt = ON;
                        pcnt_nxt  = '0;
                    end else begin
                        pcnt_nxt = pcnt + 1'b1;
                    end
                end
            end
            ON: begin
                if (tick) begin
                    if (pcnt == ON_LAST) begin
                        state_nxt = BLANK;
                        pcnt_nxt  = '0;
                        dig_nxt   = dig + 2'd1;
                        boundary  = (dig == 2'd3);
                    end else begin
                        pcnt_nxt = pcnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = BLANK;
                pcnt_nxt  = '0;
            end
        endcase
    end

    // A load landing on the boundary bypasses the pending register entirely
    always_comb begin
        act_val_nxt = act_val;
        act_dp_nxt  = act_dp;
        act_dis_nxt = act_dis;
        pend_nxt    = pend;
        if (boundary) begin
            pend_nxt = 1'b0;
            if (load) begin
                act_val_nxt = value_in;
                act_dp_nxt  = dp_in;
                act_dis_nxt = ~en_in;
            end else if (pend) begin
                act_val_nxt = pnd_val;
                act_dp_nxt  = pnd_dp;
                act_dis_nxt = pnd_dis;
            end
        end else if (load) begin
            pend_nxt = 1'b1;
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    assign lz_mask = leading_zero_mask(act_val_nxt, act_dp_nxt);
`else
    assign lz_mask = '0;
`endif

    assign nibble = act_val_nxt[{dig_nxt, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble (nibble),
        .seg    (seg_dec)
    );

    // Pins are computed from next-state values so they change on the transition edge
    always_comb begin
        dark     = act_dis_nxt[dig_nxt] | lz_mask[dig_nxt];
        an_nxt   = 4'b1111;
        seg_nxt  = SEG_OFF;
        dp_n_nxt = 1'b1;
        if (state_nxt == ON) begin
            an_nxt   = dark ? 4'b1111 : an_select(dig_nxt);
            seg_nxt  = seg_dec;
            dp_n_nxt = ~act_dp_nxt[dig_nxt];
        end
    end

    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            tcnt       <= '0;
            pcnt       <= '0;
            state      <= BLANK;
            dig        <= 2'd0;
            act_val    <= '0;
            act_dp     <= '0;
            act_dis    <= '0;
            pnd_val    <= '0;
            pnd_dp     <= '0;
            pnd_dis    <= '0;
            pend       <= 1'b0;
            an         <= 4'b1111;
            seg        <= SEG_OFF;
            dp_n       <= 1'b1;
            frame_done <= 1'b0;
        end else begin
            tcnt       <= tick ? '0 : tcnt + 1'b1;
            pcnt       <= pcnt_nxt;
            state      <= state_nxt;
            dig        <= dig_nxt;
            act_val    <= act_val_nxt;
            act_dp     <= act_dp_nxt;
            act_dis    <= act_dis_nxt;
            pend       <= pend_nxt;
            if (load) begin
                pnd_val <= value_in;
                pnd_dp  <= dp_in;
                pnd_dis <= ~en_in;
            end
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp_n       <= dp_n_nxt;
            frame_done <= boundary;
        end
    end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

- Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display.
- Runs on the 100 MHz system clock. Uses an internal clock-enable prescaler, not a derived clock.
- Walks the digits with a blanking guard between them to stop ghosting, double-buffers the displayed value, and commits new values only at frame boundaries.
- Sits between the display-data producers (counters, FSM status) and the board pins.

## Interface
- `TICK_DIV`, default 100000: system clocks per scan tick (≥2).
- `BLANK_TICKS`, default 1: ticks per digit with all anodes off (≥1).
- `ON_TICKS`, default 4: ticks per digit with the anode driven (≥1).
- `clk_100MHz`, in, 1: system clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `load`, in, 1: single-cycle strobe that captures `value_in`, `dp_in` and `en_in`.
- `value_in`, in, 16: four hex nibbles; `[3:0]` is digit 0 (rightmost).
- `dp_in`, in, 4: decimal point per digit, 1 = lit.
- `en_in`, in, 4: per-digit enable, 0 = digit dark.
- `an`, out, 4: anodes, active-low.
- `seg`, out, 7: segments `{g,f,e,d,c,b,a}`, active-low.
- `dp_n`, out, 1: decimal point, active-low.
- `frame_done`, out, 1: one-cycle pulse when digit 3's ON phase ends.

## Operation
- **Prescaler:** `tcnt` counts 0..`TICK_DIV`-1 and wraps. `tick` = (`tcnt`==`TICK_DIV`-1).
- **FSM states:** `BLANK`, `ON`. Phase counter `pcnt`. Digit index `dig` is 2 bits.
  - `BLANK`: on `tick`, `pcnt`++. At `BLANK_TICKS` ticks, go to `ON` and clear `pcnt`.
  - `ON`: on `tick`, `pcnt`++. At `ON_TICKS` ticks, go to `BLANK`, clear `pcnt`, and do `dig`++ (3 wraps to 0).
- **Buffering:**
  - `load` writes a pending register and sets `pend`.
  - The frame boundary is the `ON`→`BLANK` transition with `dig`==3.
  - At the boundary, if `pend` is set, the active register takes the pending contents and `pend` clears.
  - If `load` and the boundary coincide, `value_in`, `dp_in` and `en_in` go straight to the active register and `pend` ends cleared.
  - A `load` during a frame never alters the digits of that frame.
- **Outputs in `BLANK`:** `an`=4'b1111, `seg`=7'h7F, `dp_n`=1.
- **Outputs in `ON`:**
  - `an`=~(1<<`dig`), unless active `en[dig]`==0, in which case `an`=4'b1111.
  - `seg` = decoded active nibble `dig`, hex 0-F.
  - `dp_n` = ~active `dp[dig]`.
- **Timing of a disabled digit:** it still occupies its slot, so refresh rate and brightness are independent of the enable mask.
- **Reset values:** `an`=4'b1111, `seg`=7'h7F, `dp_n`=1, `frame_done`=0. Internally `tcnt`=0, `pcnt`=0, `dig`=0, state `BLANK`, active and pending registers 0, `pend`=0.
- **Reset mid-frame:** applies immediately and asynchronously. The frame restarts at digit 0 in `BLANK`, and any pending load is discarded.

## Timing
- All outputs are registered and update on the same edge as the state transition, with no combinational path from inputs to pins.
- Each digit slot lasts (`BLANK_TICKS`+`ON_TICKS`)×`TICK_DIV` clocks, and a frame is four slots.
- Defaults give a 5 ms slot, a 20 ms frame and 50 Hz refresh.
- `frame_done` is high for exactly the cycle after the boundary edge.
- A `load` reaches the pins at the start of the next frame's digit 0 `ON` phase. Worst case is one frame plus one `BLANK` phase.

## Configuration
- `SEG7_LEADING_ZERO_BLANK_EN` defined:
  - Digits 3, 2 and 1 are forced dark (`an` high) while their nibble is 0, their `dp` is 0, and every higher digit is also blanked this way.
  - Digit 0 is never suppressed.
  - The suppression is computed from the active register.
- Undefined: all enabled digits show their nibble, including zeros.

## Structure
- **Package `seg7_pkg`:**
  - Seven-segment pattern constants for 0-F, active-low.
  - `SEG_OFF`=7'h7F.
  - `NUM_DIGITS`=4.
  - The `BLANK`/`ON` state typedef.
- **Sub-module `seg7_decode`:** combinational nibble→segment lookup, one instance fed by the active nibble mux.

## Test plan
Bench parameters: `TICK_DIV`=4, `BLANK_TICKS`=1, `ON_TICKS`=2, giving 12-clock slots and 48-clock frames.
- **Reset values:** assert `rst` → `an`=4'hF, `seg`=7'h7F, `dp_n`=1 and `frame_done`=0 for the whole reset. The first `an`=4'b1110 appears 4 clocks after release.
- **Basic scan:** `load` `value_in`=16'h1234, `en_in`=4'hF, `dp_in`=4'b0100 → the next frame shows:
  - digit 0: `an`=1110, `seg`=7'h19 ("4");
  - digit 1: `an`=1101, `seg`=7'h30 ("3");
  - digit 2: `an`=1011, `seg`=7'h24 ("2"), `dp_n`=0;
  - digit 3: `an`=0111, `seg`=7'h79 ("1").
- **Mid-frame load:** `load` 16'hABCD during digit 1 of a frame showing 16'h1234 → digits 1-3 still show 3, 2, 1. The next frame shows D, C, B, A, and `frame_done` pulses once per 48 clocks.
- **Simultaneous load and boundary:** `load` in the boundary cycle with 16'h00F0 → the next frame shows 0, F, 0, 0 and `pend` is 0.
- **Enable mask and leading zeros:** `en_in`=4'b1010 → `an` stays 4'hF in the digit 0 and digit 2 slots with slot timing unchanged. With the macro defined, `value_in`=16'h0005 and `en_in`=4'hF → digits 3, 2 and 1 are dark and digit 0 shows "5".
- **Reset mid-frame:** assert `rst` during digit 2 `ON` with a pending load → outputs go to reset values immediately. After release, the old active value is gone, all digits show 0, and the pending value is never displayed.
